// File: rtl/ibexc_tsmap_arb.sv
// Arbiter/sequencer for the temporal-safety bitmap SRAM: core reads first,
// then a round-robin between the bus port and the background clear engine.
module ibexc_tsmap_arb #(
    parameter int unsigned TSMapSize   = 1024,
    parameter int unsigned AddrW       = 16,
    parameter int unsigned StarveLimit = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             core_cs_i,
    input  logic [AddrW-1:0] core_addr_i,
    output logic [31:0]      core_rdata_o,
    input  logic             bus_req_i,
    input  logic             bus_we_i,
    input  logic [3:0]       bus_be_i,
    input  logic [AddrW-1:0] bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    output logic             bus_gnt_o,
    output logic             bus_rvalid_o,
    output logic [31:0]      bus_rdata_o,
    output logic             bus_err_o,
    input  logic             clr_start_i,
    input  logic [AddrW-1:0] clr_base_i,
    input  logic [AddrW-1:0] clr_count_i,
    output logic             clr_busy_o,
    output logic             clr_done_o,
    output logic             clr_err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             starve_o
);

    typedef enum logic [1:0] {
        ClrIdle,
        ClrRun,
        ClrDone
    } clr_state_e;

    localparam logic [AddrW:0]   MapEnd    = (AddrW+1)'(TSMapSize);
    localparam logic [AddrW-1:0] AddrOne   = AddrW'(1);
    localparam logic [15:0]      StarveMax = 16'(StarveLimit);

    clr_state_e       state_q, state_d;
    logic [AddrW-1:0] cur_q, cur_d;
    logic [AddrW-1:0] rem_q, rem_d;
    logic             clr_err_q, clr_err_d;
    logic             rr_bus_q, rr_bus_d;
    logic             rv_q, rerr_q, rrd_q;
    logic [15:0]      starve_q, starve_d;

    logic             clr_pend, clr_gnt, bus_oob, start_bad, any_pend;
    logic [AddrW:0]   clr_end;

    assign clr_pend  = (state_q == ClrRun);
    assign bus_oob   = ({1'b0, bus_addr_i} >= MapEnd);
    assign bus_gnt_o = bus_req_i & ~core_cs_i & (rr_bus_q | ~clr_pend);
    assign clr_gnt   = clr_pend & ~core_cs_i & ~bus_gnt_o;
    assign any_pend  = bus_req_i | clr_pend;

    assign clr_end   = {1'b0, clr_base_i} + {1'b0, clr_count_i};
    assign start_bad = (clr_count_i == '0) || (clr_end > MapEnd);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        clr_err_d = 1'b0;
        unique case (state_q)
            ClrIdle: begin
                if (clr_start_i) begin
                    if (start_bad) begin
                        clr_err_d = 1'b1;
                    end else begin
                        cur_d   = clr_base_i;
                        rem_d   = clr_count_i;
                        state_d = ClrRun;
                    end
                end
            end
            ClrRun: begin
                if (clr_gnt) begin
                    cur_d = cur_q + AddrOne;
                    rem_d = rem_q - AddrOne;
                    if (rem_q == AddrOne) state_d = ClrDone;
                end
            end
            ClrDone: state_d = ClrIdle;
            default: state_d = ClrIdle;
        endcase
    end

    // Pointer hands the next contested slot to whoever did not just win.
    always_comb begin
        rr_bus_d = rr_bus_q;
        if (bus_gnt_o)    rr_bus_d = 1'b0;
        else if (clr_gnt) rr_bus_d = 1'b1;
    end

    always_comb begin
        starve_d = starve_q;
        if (bus_gnt_o || clr_gnt || !any_pend) begin
            starve_d = '0;
        end else if (core_cs_i && (starve_q != StarveMax)) begin
            starve_d = starve_q + 16'd1;
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (core_cs_i) begin
            mem_req_o  = 1'b1;
            mem_addr_o = core_addr_i;
        end else if (bus_gnt_o && !bus_oob) begin
            mem_req_o   = 1'b1;
            mem_we_o    = bus_we_i;
            mem_be_o    = bus_we_i ? bus_be_i : 4'b1111;
            mem_addr_o  = bus_addr_i;
            mem_wdata_o = bus_we_i ? bus_wdata_i : 32'h0;
        end else if (clr_gnt) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_be_o   = 4'b1111;
            mem_addr_o = cur_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ClrIdle;
            cur_q     <= '0;
            rem_q     <= '0;
            clr_err_q <= 1'b0;
            rr_bus_q  <= 1'b1;
            rv_q      <= 1'b0;
            rerr_q    <= 1'b0;
            rrd_q     <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rem_q     <= rem_d;
            clr_err_q <= clr_err_d;
            rr_bus_q  <= rr_bus_d;
            rv_q      <= bus_gnt_o;
            rerr_q    <= bus_gnt_o & bus_oob;
            rrd_q     <= bus_gnt_o & ~bus_we_i & ~bus_oob;
            starve_q  <= starve_d;
        end
    end

    assign core_rdata_o = mem_rdata_i;
    assign bus_rvalid_o = rv_q;
    assign bus_err_o    = rerr_q;
    assign bus_rdata_o  = rrd_q ? mem_rdata_i : 32'h0;
    assign clr_busy_o   = (state_q != ClrIdle);
    assign clr_done_o   = (state_q == ClrDone);
    assign clr_err_o    = clr_err_q;
    assign starve_o     = (starve_q == StarveMax);

endmodule

// File: tb/tb_ibexc_tsmap_arb.sv
// Randomized and directed bench for ibexc_tsmap_arb against a queue-based
// reference model of the bitmap contents, arbitration and clear engine.
module tb_ibexc_tsmap_arb;

    localparam int N  = 1024;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_cs = 1'b0;
    logic [15:0] core_addr = '0;
    logic [31:0] core_rdata;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_be = '0;
    logic [15:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;
    logic        clr_start = 1'b0;
    logic [15:0] clr_base = '0;
    logic [15:0] clr_count = '0;
    logic        clr_busy, clr_done, clr_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        starve;

    ibexc_tsmap_arb #(
        .TSMapSize  (N),
        .AddrW      (16),
        .StarveLimit(SL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .core_cs_i   (core_cs),
        .core_addr_i (core_addr),
        .core_rdata_o(core_rdata),
        .bus_req_i   (bus_req),
        .bus_we_i    (bus_we),
        .bus_be_i    (bus_be),
        .bus_addr_i  (bus_addr),
        .bus_wdata_i (bus_wdata),
        .bus_gnt_o   (bus_gnt),
        .bus_rvalid_o(bus_rvalid),
        .bus_rdata_o (bus_rdata),
        .bus_err_o   (bus_err),
        .clr_start_i (clr_start),
        .clr_base_i  (clr_base),
        .clr_count_i (clr_count),
        .clr_busy_o  (clr_busy),
        .clr_done_o  (clr_done),
        .clr_err_o   (clr_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .starve_o    (starve)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // SRAM macro stand-in with one-cycle read latency
    logic [31:0] sram [0:N-1];
    always @(posedge clk) begin
        if (mem_req && mem_addr < 16'(N)) begin
            if (mem_we) sram[mem_addr] = merge(sram[mem_addr], mem_wdata, mem_be);
            else mem_rdata <= sram[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model state
    logic [31:0] ref_mem [0:N-1];
    int          clr_q[$];
    bit          fav_bus, m_done, m_err;
    int          starve_n;
    bit          exp_rv, exp_err, exp_cv;
    logic [31:0] exp_rd, exp_cd;

    task automatic model_reset();
        clr_q.delete();
        fav_bus  = 1'b1;
        m_done   = 1'b0;
        m_err    = 1'b0;
        starve_n = 0;
        exp_rv   = 1'b0;
        exp_err  = 1'b0;
        exp_cv   = 1'b0;
        exp_rd   = '0;
        exp_cd   = '0;
    endtask

    task automatic tick();
        bit eg, ec, oob, pend, idle;
        int a;
        @(negedge clk);
        oob = (int'(bus_addr) >= N);
        eg  = bus_req && !core_cs && (clr_q.size() == 0 || fav_bus);
        ec  = (clr_q.size() != 0) && !core_cs && !eg;
        chk("bus_gnt", 32'(bus_gnt), 32'(eg));
        if (core_cs) begin
            chk("core_mreq", 32'(mem_req), 1);
            chk("core_mwe", 32'(mem_we), 0);
            chk("core_maddr", 32'(mem_addr), 32'(core_addr));
        end else if (eg && !oob) begin
            chk("bus_mreq", 32'(mem_req), 1);
            chk("bus_mwe", 32'(mem_we), 32'(bus_we));
            chk("bus_maddr", 32'(mem_addr), 32'(bus_addr));
            if (bus_we) begin
                chk("bus_mbe", 32'(mem_be), 32'(bus_be));
                chk("bus_mwdata", mem_wdata, bus_wdata);
            end
        end else if (ec) begin
            chk("clr_mreq", 32'(mem_req), 1);
            chk("clr_mwe", 32'(mem_we), 1);
            chk("clr_maddr", 32'(mem_addr), 32'(clr_q[0]));
            chk("clr_mbe", 32'(mem_be), 32'hF);
            chk("clr_mwdata", mem_wdata, 0);
        end else begin
            chk("idle_mreq", 32'(mem_req), 0);
        end
        chk("rvalid", 32'(bus_rvalid), 32'(exp_rv));
        chk("rerr", 32'(bus_err), 32'(exp_err));
        chk("rdata", bus_rdata, exp_rd);
        if (exp_cv) chk("core_rdata", core_rdata, exp_cd);
        chk("clr_busy", 32'(clr_busy), 32'((clr_q.size() != 0) || m_done));
        chk("clr_done", 32'(clr_done), 32'(m_done));
        chk("clr_err", 32'(clr_err), 32'(m_err));
        chk("starve", 32'(starve), 32'(starve_n == SL));
        @(posedge clk);
        exp_cv = core_cs;
        if (core_cs) exp_cd = ref_mem[int'(core_addr)];
        exp_rv  = eg;
        exp_err = eg && oob;
        exp_rd  = (eg && !bus_we && !oob) ? ref_mem[int'(bus_addr)] : 32'h0;
        if (eg && bus_we && !oob) begin
            a = int'(bus_addr);
            ref_mem[a] = merge(ref_mem[a], bus_wdata, bus_be);
        end
        pend = bus_req || (clr_q.size() != 0);
        if (eg || ec || !pend) starve_n = 0;
        else if (core_cs && starve_n < SL) starve_n++;
        idle   = (clr_q.size() == 0) && !m_done;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (eg) fav_bus = 1'b0;
        if (ec) begin
            ref_mem[clr_q[0]] = '0;
            void'(clr_q.pop_front());
            fav_bus = 1'b1;
            if (clr_q.size() == 0) m_done = 1'b1;
        end
        if (clr_start && idle) begin
            if (clr_count == 0 || int'(clr_base) + int'(clr_count) > N) m_err = 1'b1;
            else for (int i = 0; i < int'(clr_count); i++) clr_q.push_back(int'(clr_base) + i);
        end
        #1;
    endtask

    task automatic idle_inputs();
        core_cs   = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_gnt", 32'(bus_gnt), 0);
        chk("rst_rvalid", 32'(bus_rvalid), 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_err", 32'(bus_err), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_done", 32'(clr_done), 0);
        chk("rst_clr_err", 32'(clr_err), 0);
        chk("rst_mreq", 32'(mem_req), 0);
        chk("rst_mwe", 32'(mem_we), 0);
        chk("rst_starve", 32'(starve), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic bus_op(input bit we, input logic [15:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_be    = be;
        bus_wdata = wd;
    endtask

    initial begin
        int n;
        logic [31:0] v;
        for (int i = 0; i < N; i++) begin
            v = $urandom;
            sram[i] = v;
            ref_mem[i] = v;
        end
        sram[5] = 32'hA5A5_0001;
        ref_mem[5] = 32'hA5A5_0001;
        sram[3] = 32'hFFFF_FFFF;
        ref_mem[3] = 32'hFFFF_FFFF;
        #3;
        do_reset();
        tick();

        // core read wins over a simultaneous bus request
        core_cs = 1'b1;
        core_addr = 16'd5;
        bus_op(1'b0, 16'd7, 4'hF, 32'h0);
        tick();
        chk("core5_data", core_rdata, 32'hA5A5_0001);
        core_cs = 1'b0;
        tick();
        idle_inputs();
        tick();

        // partial write then readback
        bus_op(1'b1, 16'd3, 4'b0011, 32'h1234_5678);
        tick();
        bus_op(1'b0, 16'd3, 4'hF, 32'h0);
        tick();
        chk("rd3_data", bus_rdata, 32'hFFFF_5678);
        idle_inputs();
        tick();

        // out-of-range read
        bus_op(1'b0, 16'd1024, 4'hF, 32'h0);
        tick();
        chk("oob_err", 32'(bus_err), 1);
        idle_inputs();
        tick();

        // uncontended clear of 10..13
        clr_base = 16'd10;
        clr_count = 16'd4;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (!clr_done && n < 20) begin
            tick();
            n++;
        end
        chk("clr4_cycles", 32'(n), 4);
        tick();
        chk("clr4_busy_fall", 32'(clr_busy), 0);

        // rejected start: range overruns the map
        clr_base = 16'd1022;
        clr_count = 16'd4;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("clr_bad_err", 32'(clr_err), 1);
        tick();
        tick();

        // clear under continuous bus traffic
        clr_base = 16'd0;
        clr_count = 16'd8;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (!clr_done && n < 40) begin
            bus_op(1'($urandom), 16'($urandom_range(N-1)), 4'($urandom), $urandom);
            tick();
            n++;
        end
        chk("clr8_contended_cycles", 32'(n), 16);
        idle_inputs();
        tick();
        tick();

        // starvation: core hogs the port while the bus waits
        core_cs = 1'b1;
        core_addr = 16'd20;
        bus_op(1'b0, 16'd21, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("starve_pre", 32'(starve), 0);
        tick();
        chk("starve_set", 32'(starve), 1);
        tick();
        tick();
        core_cs = 1'b0;
        tick();
        chk("starve_clear", 32'(starve), 0);
        idle_inputs();
        tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            core_cs   = ($urandom_range(2) == 0);
            core_addr = 16'($urandom_range(N-1));
            bus_req   = 1'($urandom);
            bus_we    = 1'($urandom);
            bus_be    = 4'($urandom);
            bus_wdata = $urandom;
            bus_addr  = ($urandom_range(7) == 0) ? 16'(N + $urandom_range(200))
                                                 : 16'($urandom_range(N-1));
            clr_start = ($urandom_range(29) == 0);
            clr_base  = 16'($urandom_range(N-1));
            clr_count = 16'($urandom_range(24));
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 30; i++) tick();

        // reset in the middle of a clear with a response outstanding
        clr_base = 16'd100;
        clr_count = 16'd20;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        bus_op(1'b0, 16'd200, 4'hF, 32'h0);
        tick();
        do_reset();
        chk("rst_mid_busy", 32'(clr_busy), 0);
        chk("rst_mid_rvalid", 32'(bus_rvalid), 0);
        for (int i = 0; i < 5; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ibexc_tsmap_arb.md
# ibexc_tsmap_arb

Single-port arbiter and sequencer for the CHERIoT temporal-safety (revocation) bitmap SRAM. It shares the memory between three requesters. The core's fixed-latency tsmap read port always has priority. A bus-side read/write port (ibex req/gnt/rvalid protocol) is used by the software revoker and allocator. A built-in clear engine zeroes a contiguous word range in the background. The block sits between the ibexc core top and the tsmap SRAM macro.

## Interface
Parameters:
- TSMapSize, 1024: bitmap depth in 32-bit words; legal word addresses are 0..TSMapSize-1.
- AddrW, 16: word-address width of all ports.
- StarveLimit, 255: count of consecutive core-blocked cycles that asserts starve_o (1..65535).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_cs_i  in  1  core bitmap read strobe; never stalled
- core_addr_i  in  AddrW  core read word address
- core_rdata_o  out  32  core read data, valid the cycle after core_cs_i
- bus_req_i  in  1  bus request
- bus_we_i  in  1  1 = write, 0 = read
- bus_be_i  in  4  write byte enables
- bus_addr_i  in  AddrW  bus word address
- bus_wdata_i  in  32  bus write data
- bus_gnt_o  out  1  request accepted this cycle
- bus_rvalid_o  out  1  response valid, exactly one per grant
- bus_rdata_o  out  32  read data (0 for writes and errors)
- bus_err_o  out  1  response error (address out of range)
- clr_start_i  in  1  start clear engine (pulse)
- clr_base_i  in  AddrW  first word to clear
- clr_count_i  in  AddrW  number of words to clear
- clr_busy_o  out  1  clear engine active
- clr_done_o  out  1  one-cycle pulse when the last word has been written
- clr_err_o  out  1  one-cycle pulse when a start is rejected
- mem_req_o, mem_we_o  out  1 each  SRAM strobe and write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  AddrW  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, 1-cycle latency
- starve_o  out  1  bus/clear starvation flag

## Operation
- Priority: core > {bus, clear}. Bus and clear share a round-robin pointer. The pointer flips to the other requester after each bus or clear grant. Reset value favours bus.
- Core cycle (core_cs_i=1): mem_req_o=1, mem_we_o=0, mem_addr_o=core_addr_i. No bus grant and no clear write that cycle.
- Bus grant: requires bus_req_i=1 and core_cs_i=0, and either round-robin selects bus or no clear write is pending.
  - In range: the SRAM access is issued the same cycle, with mem_be_o=bus_be_i on writes.
  - Address ≥ TSMapSize: no SRAM access. The response carries bus_err_o=1 and rdata 0.
- Clear engine states:
  - IDLE: on clr_start_i, if clr_count_i=0, or clr_base_i+clr_count_i > TSMapSize (computed in AddrW+1 bits), pulse clr_err_o and stay in IDLE. Otherwise latch cur=clr_base_i and rem=clr_count_i, then go to RUN.
  - RUN: when selected, write 0 with be=1111 to cur; then cur+1 and rem-1. When the write with rem=1 is granted, go to DONE.
  - DONE: pulse clr_done_o for one cycle, then return to IDLE.
  - clr_start_i outside IDLE is ignored, with no error.
- Response-owner flop: records whether a bus response is due next cycle. bus_rdata_o = mem_rdata_i only for an in-range bus read response, else 0.
- core_rdata_o is mem_rdata_i passed straight through. The core samples it only the cycle after its own strobe.
- Starvation counter: 16-bit, saturating at StarveLimit.
  - Increments on each cycle where (bus_req_i or a RUN write is pending) and core_cs_i=1.
  - Clears on any bus or clear grant, and when no requester is pending.
  - starve_o = (counter == StarveLimit).
- Ordering: a bus write followed by a core read of the same word returns the new value. Per-cycle SRAM ordering is sufficient; no forwarding.

## Timing
- Reset values: all outputs 0; FSM IDLE; counter 0; round-robin favours bus; owner flop cleared.
- bus_gnt_o is combinational from bus_req_i, core_cs_i and state. bus_rvalid_o comes exactly 1 cycle after bus_gnt_o. Back-to-back grants give back-to-back responses.
- Core read latency is 1 cycle, unconditionally.
- Clear throughput: 1 word/cycle with no contention; 1 word per 2 cycles when the bus requests continuously.
- clr_busy_o is high from the cycle after an accepted start through the DONE cycle.
- Reset asserted mid-clear or mid-response aborts the operation. Pending rvalid and done are dropped; no pulse is emitted after reset.

## Test plan
- Core cs on addr 5 with SRAM word 5 = 0xA5A5_0001 → core_rdata_o = 0xA5A5_0001 next cycle; bus_req held the same cycle → bus_gnt_o=0, then granted the following cycle.
- Bus write addr 3, be=0011, data 0x1234_5678 over 0xFFFF_FFFF; then bus read addr 3 → rvalid each 1 cycle after gnt, rdata 0xFFFF_5678.
- Bus read addr 1024 (TSMapSize=1024) → gnt, next cycle rvalid with err=1, rdata 0, no mem_req_o.
- clr_start base=10, count=4 with bus idle → four consecutive zero writes to 10..13, clr_done_o pulse, busy falls; base=1022, count=4 → clr_err_o pulse, no writes.
- Clear base=0, count=8 with bus_req continuously high → grants alternate bus/clear; done after 16 arbitration cycles.
- StarveLimit=4, core_cs_i held high with bus_req → starve_o rises after 4 blocked cycles, and falls after the first grant once cs drops.
